// File: rtl/ct_rtu_encode_pipe.sv
// Registered one-hot to binary encoder with a 2-entry skid buffer.
// The input vector is encoded at push time. The head entry drives the outputs.
// Zero-hot and multi-hot inputs are flagged with the entry and counted.
module ct_rtu_encode_pipe #(
  parameter int WIDTH = 64,
  parameter int ENC_W = $clog2(WIDTH),
  parameter int CNT_W = 8
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             x_vld,
  output logic             x_rdy,
  input  logic [WIDTH-1:0] x_num_expand,
  input  logic             x_prio_mode,
  output logic             x_num_vld,
  input  logic             x_num_rdy,
  output logic [ENC_W-1:0] x_num,
  output logic             x_num_zero,
  output logic             x_num_multi,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_cnt_clr
);

  typedef struct packed {
    logic [ENC_W-1:0] num;
    logic             zero;
    logic             multi;
  } ent_t;

  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  logic [ENC_W-1:0] or_idx, pri_idx;
  ent_t             new_ent, ent0, ent1;
  logic [1:0]       cnt;
  logic             push, pop;

  // Encode both modes in one scan.
  // The scan runs from the top index downward, so the last hit is the lowest set index.
  always_comb begin
    or_idx  = '0;
    pri_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x_num_expand[i]) begin
        or_idx  = or_idx | ENC_W'(i);
        pri_idx = ENC_W'(i);
      end
    end
  end

  // Build the entry as it would be stored on push.
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  always_comb begin
    new_ent.num   = x_prio_mode ? pri_idx : or_idx;
    new_ent.zero  = ~|x_num_expand;
    new_ent.multi = |(x_num_expand & (x_num_expand - WIDTH'(1)));
  end

  // x_rdy comes only from registered occupancy.
  // It has no combinational path from x_num_rdy.
  assign x_rdy       = (cnt != 2'd2);
  assign x_num_vld   = (cnt != 2'd0);
  assign push        = x_vld & x_rdy;
  assign pop         = x_num_vld & x_num_rdy;
  assign x_num       = ent0.num;
  assign x_num_zero  = ent0.zero;
  assign x_num_multi = ent0.multi;

  // Skid buffer: ent0 is the head.
  // A pop shifts ent1 forward, and a push fills the first free slot after that shift.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (pop && cnt == 2'd2) ent0 <= ent1;
      if (push) begin
        if (cnt == 2'd0 || (cnt == 2'd1 && pop)) ent0 <= new_ent;
        else                                     ent1 <= new_ent;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Saturating count of accepted erroneous inputs.
  // A clear takes priority over an increment in the same cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)                                              err_cnt <= '0;
    else if (err_cnt_clr)                                       err_cnt <= '0;
    else if (push && (new_ent.zero || new_ent.multi) && err_cnt != ERR_MAX)
                                                                err_cnt <= err_cnt + 1'b1;
  end

endmodule
